retry_qos_scheduler: RTL and testbench

RETRY_QOS_SCHEDULER -- requirements
Module: retry_qos_scheduler

---
 rtl/retry_qos_scheduler.sv | 152 +++++++++++++++
 tb/tb_retry_qos_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/retry_qos_scheduler.sv
// Retry-buffer replay scheduler: per-class occupancy counters, weighted round-robin
// with credit reload, and an age-based anti-starvation override.
module retry_qos_scheduler #(
   parameter int ENTYR_NUM     = 32,
   parameter int QOS_CLASS_NUM = 4,
   parameter int WEIGHT_W      = 4,
   parameter int STARVE_CYC    = 64,
   localparam int QW = $clog2(QOS_CLASS_NUM),
   localparam int CW = $clog2(ENTYR_NUM) + 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic [QW-1:0]                     qos_in,
   input  logic [QOS_CLASS_NUM*WEIGHT_W-1:0] cfg_weight,
   input  logic                              out_rdy,
   output logic                              wr_acc,
   output logic                              wr_drop,
   output logic [QOS_CLASS_NUM-1:0]          rd_en,
   output logic [QW-1:0]                     qos_out,
   output logic                              gnt_vld,
   output logic                              full,
   output logic [CW-1:0]                     occ
);
   localparam int            AW      = $clog2(STARVE_CYC + 1);
   localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_CYC);
   localparam logic [QW-1:0] LAST    = QW'(QOS_CLASS_NUM - 1);

   logic [CW-1:0]       cnt_q    [QOS_CLASS_NUM];
   logic [CW-1:0]       cnt_d    [QOS_CLASS_NUM];
   logic [WEIGHT_W-1:0] credit_q [QOS_CLASS_NUM];
   logic [WEIGHT_W-1:0] credit_d [QOS_CLASS_NUM];
   logic [AW-1:0]       age_q    [QOS_CLASS_NUM];
   logic [AW-1:0]       age_d    [QOS_CLASS_NUM];
   logic [QW-1:0]       ptr_q, ptr_d;

   logic [QOS_CLASS_NUM-1:0] nonempty, gnt;
   logic [QW-1:0]            gidx, st_idx, cr_idx, rr_idx, scan;
   logic                     st_hit, cr_hit, rr_hit;
   logic [WEIGHT_W-1:0]      cr_left;
   logic [CW-1:0]            occ_sum;

   function automatic logic [QW-1:0] wrap_inc(input logic [QW-1:0] i);
      return (i == LAST) ? '0 : i + 1'b1;
   endfunction

   function automatic logic [AW-1:0] age_sat_inc(input logic [AW-1:0] a);
      return (a == AGE_MAX) ? a : a + 1'b1;
   endfunction

   function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
      return (w == '0) ? WEIGHT_W'(1) : w;
   endfunction

   always_comb begin
      occ_sum = '0;
      for (int c = 0; c < QOS_CLASS_NUM; c++) occ_sum = occ_sum + cnt_q[c];
   end

   assign occ     = occ_sum;
   assign full    = (occ_sum == CW'(ENTYR_NUM));
   assign wr_acc  = rst_n & wr_en & ~full;
   assign wr_drop = rst_n & wr_en & full;

   always_comb begin
      st_hit   = 1'b0;
      cr_hit   = 1'b0;
      rr_hit   = 1'b0;
      st_idx   = '0;
      cr_idx   = '0;
      rr_idx   = '0;
      gidx     = '0;
      gnt      = '0;
      cr_left  = '0;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      for (int c = 0; c < QOS_CLASS_NUM; c++) nonempty[c] = (cnt_q[c] != '0);
      // Descending scan so the lowest starving index is the one left standing.
      for (int c = QOS_CLASS_NUM - 1; c >= 0; c--) begin
         if (nonempty[c] && age_q[c] == AGE_MAX) begin
            st_hit = 1'b1;
            st_idx = QW'(c);
         end
      end
      scan = ptr_q;
      for (int k = 0; k < QOS_CLASS_NUM; k++) begin
         if (!cr_hit && nonempty[scan] && credit_q[scan] != '0) begin
            cr_hit = 1'b1;
            cr_idx = scan;
         end
         if (!rr_hit && nonempty[scan]) begin
            rr_hit = 1'b1;
            rr_idx = scan;
         end
         scan = wrap_inc(scan);
      end
      if (out_rdy && (|nonempty)) begin
         if (st_hit) begin
            gidx = st_idx;
            if (credit_q[st_idx] != '0) credit_d[st_idx] = credit_q[st_idx] - 1'b1;
         end else if (cr_hit) begin
            gidx             = cr_idx;
            cr_left          = credit_q[cr_idx] - 1'b1;
            credit_d[cr_idx] = cr_left;
            ptr_d            = (cr_left == '0) ? wrap_inc(cr_idx) : cr_idx;
         end else begin
            // Every nonempty class is out of credit: refill all from the live weights.
            for (int c = 0; c < QOS_CLASS_NUM; c++)
               credit_d[c] = eff_weight(cfg_weight[c*WEIGHT_W +: WEIGHT_W]);
            gidx             = rr_idx;
            cr_left          = eff_weight(cfg_weight[int'(rr_idx)*WEIGHT_W +: WEIGHT_W]) - 1'b1;
            credit_d[rr_idx] = cr_left;
            ptr_d            = (cr_left == '0) ? wrap_inc(rr_idx) : rr_idx;
         end
         gnt[gidx] = 1'b1;
      end
   end

   assign rd_en   = gnt;
   assign gnt_vld = |gnt;
   assign qos_out = gidx;

   always_comb begin
      for (int c = 0; c < QOS_CLASS_NUM; c++) begin
         cnt_d[c] = cnt_q[c];
         if (wr_acc && qos_in == QW'(c) && !gnt[c])
            cnt_d[c] = cnt_q[c] + 1'b1;
         else if (gnt[c] && !(wr_acc && qos_in == QW'(c)))
            cnt_d[c] = cnt_q[c] - 1'b1;
         age_d[c] = (gnt[c] || cnt_q[c] == '0) ? '0 : age_sat_inc(age_q[c]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         for (int c = 0; c < QOS_CLASS_NUM; c++) begin
            cnt_q[c]    <= '0;
            credit_q[c] <= '0;
            age_q[c]    <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         for (int c = 0; c < QOS_CLASS_NUM; c++) begin
            cnt_q[c]    <= cnt_d[c];
            credit_q[c] <= credit_d[c];
            age_q[c]    <= age_d[c];
         end
      end
   end

endmodule

// File: tb/tb_retry_qos_scheduler.sv
// Directed bench for retry_qos_scheduler: expected grants are queued by the stimulus
// and consumed by per-instance monitors; occupancy and flags are checked inline.
module tb_retry_qos_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Default instance (ENTYR_NUM=32, STARVE_CYC=64)
   logic        wr_en, out_rdy, wr_acc, wr_drop, gnt_vld, full;
   logic [1:0]  qos_in, qos_out;
   logic [15:0] cfg;
   logic [3:0]  rd_en;
   logic [5:0]  occ;

   // Short-starvation instance (STARVE_CYC=4)
   logic        s_wr_en, s_out_rdy, s_wr_acc, s_wr_drop, s_gnt_vld, s_full;
   logic [1:0]  s_qos_in, s_qos_out;
   logic [15:0] s_cfg;
   logic [3:0]  s_rd_en;
   logic [5:0]  s_occ;

   retry_qos_scheduler dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .qos_in(qos_in), .cfg_weight(cfg),
      .out_rdy(out_rdy), .wr_acc(wr_acc), .wr_drop(wr_drop), .rd_en(rd_en),
      .qos_out(qos_out), .gnt_vld(gnt_vld), .full(full), .occ(occ));

   retry_qos_scheduler #(.STARVE_CYC(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .qos_in(s_qos_in), .cfg_weight(s_cfg),
      .out_rdy(s_out_rdy), .wr_acc(s_wr_acc), .wr_drop(s_wr_drop), .rd_en(s_rd_en),
      .qos_out(s_qos_out), .gnt_vld(s_gnt_vld), .full(s_full), .occ(s_occ));

   int n_tests = 0;
   int n_fail  = 0;
   logic [1:0] exp_q[$];
   logic [1:0] sexp_q[$];
   logic [1:0] m_e, s_e;
   logic [1:0] wrr_exp [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
   logic [1:0] stv_exp [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (gnt_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL main_unexpected_grant: got class %0d, expected no grant", qos_out);
         end else begin
            m_e = exp_q.pop_front();
            chk("main_grant_class", 32'(qos_out), 32'(m_e));
            chk("main_rd_en_onehot", 32'(rd_en), 32'(4'b0001 << m_e));
         end
      end
   end

   always @(negedge clk) begin
      if (s_gnt_vld === 1'b1) begin
         if (sexp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL starve_unexpected_grant: got class %0d, expected no grant", s_qos_out);
         end else begin
            s_e = sexp_q.pop_front();
            chk("starve_grant_class", 32'(s_qos_out), 32'(s_e));
            chk("starve_rd_en_onehot", 32'(s_rd_en), 32'(4'b0001 << s_e));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wr_en = 0; qos_in = 0; out_rdy = 0; cfg = 16'h0013;
      s_wr_en = 0; s_qos_in = 0; s_out_rdy = 0; s_cfg = 16'h111F;
      #3;
      chk("rst_occ", 32'(occ), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_gnt_vld", 32'(gnt_vld), 0);
      chk("rst_qos_out", 32'(qos_out), 0);
      chk("rst_wr_acc", 32'(wr_acc), 0);
      chk("rst_wr_drop", 32'(wr_drop), 0);
      @(posedge clk); #1;
      rst_n = 1;
      tick();

      // WRR ratio: weights c0=3, c1=1, c2/c3=0 (treated as 1)
      for (int i = 0; i < 8; i++) begin
         wr_en = 1; qos_in = (i < 4) ? 2'd0 : 2'd1;
         #1 chk("wrr_wr_acc", 32'(wr_acc), 1);
         tick();
      end
      wr_en = 0;
      #1 chk("wrr_occ_loaded", 32'(occ), 8);
      foreach (wrr_exp[i]) exp_q.push_back(wrr_exp[i]);
      out_rdy = 1;
      repeat (8) tick();
      out_rdy = 0;
      #1 chk("wrr_occ_drained", 32'(occ), 0);

      // Same-class write and grant in one cycle
      wr_en = 1; qos_in = 2'd2;
      tick();
      wr_en = 0;
      #1 chk("same_occ_before", 32'(occ), 1);
      wr_en = 1; qos_in = 2'd2; out_rdy = 1;
      exp_q.push_back(2'd2);
      #1 chk("same_wr_acc", 32'(wr_acc), 1);
      tick();
      wr_en = 0; out_rdy = 0;
      #1 chk("same_occ_unchanged", 32'(occ), 1);
      out_rdy = 1;
      exp_q.push_back(2'd2);
      tick();
      out_rdy = 0;
      #1 chk("same_occ_drained", 32'(occ), 0);

      // Fill to capacity, then drop
      for (int i = 0; i < 32; i++) begin
         wr_en = 1; qos_in = 2'(i);
         tick();
      end
      wr_en = 0;
      #1 chk("full_occ", 32'(occ), 32);
      chk("full_flag", 32'(full), 1);
      wr_en = 1; qos_in = 2'd1;
      #1 chk("drop_wr_drop", 32'(wr_drop), 1);
      chk("drop_wr_acc", 32'(wr_acc), 0);
      tick();
      wr_en = 0;
      #1 chk("drop_occ_kept", 32'(occ), 32);
      // Write while full is dropped even with a grant; the grant still retires one entry
      wr_en = 1; qos_in = 2'd0; out_rdy = 1;
      exp_q.push_back(2'd3);
      #1 chk("full_grant_wr_drop", 32'(wr_drop), 1);
      tick();
      wr_en = 0; out_rdy = 0;
      #1 chk("full_grant_occ", 32'(occ), 31);
      chk("full_grant_not_full", 32'(full), 0);
      rst_n = 0;
      #1 chk("clear_occ", 32'(occ), 0);
      chk("clear_full", 32'(full), 0);
      tick();
      rst_n = 1;
      tick();

      // Reset asserted while a grant to class 1 is being presented
      wr_en = 1; qos_in = 2'd1;
      tick();
      tick();
      wr_en = 0; out_rdy = 1;
      #1 chk("midrst_pre_rd_en", 32'(rd_en), 32'h2);
      rst_n = 0;
      #1 chk("midrst_rd_en", 32'(rd_en), 0);
      chk("midrst_occ", 32'(occ), 0);
      chk("midrst_full", 32'(full), 0);
      chk("midrst_gnt_vld", 32'(gnt_vld), 0);
      out_rdy = 0;
      tick();
      rst_n = 1;
      tick();

      // Backpressure with two entries in class 1; its age saturates, so it wins over a fresh c0
      s_wr_en = 1; s_qos_in = 2'd1;
      for (int i = 0; i < 11; i++) begin
         #1 chk("bp_rd_en_idle", 32'(s_rd_en), 0);
         tick();
         if (i == 1) s_wr_en = 0;
      end
      s_wr_en = 1; s_qos_in = 2'd0;
      #1 chk("bp_rd_en_idle", 32'(s_rd_en), 0);
      tick();
      s_wr_en = 0;
      sexp_q.push_back(2'd1);
      sexp_q.push_back(2'd0);
      sexp_q.push_back(2'd1);
      s_out_rdy = 1;
      repeat (3) tick();
      s_out_rdy = 0;
      #1 chk("bp_occ_drained", 32'(s_occ), 0);
      rst_n = 0;
      tick();
      rst_n = 1;
      tick();

      // Starvation: c0 kept busy with weight 15, one entry in c3
      foreach (stv_exp[i]) sexp_q.push_back(stv_exp[i]);
      s_wr_en = 1; s_qos_in = 2'd0;
      tick();
      tick();
      s_qos_in = 2'd3; s_out_rdy = 1;
      tick();
      s_qos_in = 2'd0;
      repeat (5) tick();
      s_wr_en = 0; s_out_rdy = 0;
      #1 chk("starve_occ_mid", 32'(s_occ), 2);
      tick();
      s_out_rdy = 1;
      repeat (2) tick();
      s_out_rdy = 0;
      #1 chk("starve_occ_drained", 32'(s_occ), 0);

      @(negedge clk);
      #1;
      chk("main_queue_drained", 32'(exp_q.size()), 0);
      chk("starve_queue_drained", 32'(sexp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
